// File: rtl/countdown_timer.sv
// countdown_timer: BCD MM:SS.t countdown, one tenth-second per prescaled tick.
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN (reload preset on expiry, keep running).
module countdown_timer #(
  parameter int TICK_CYCLES = 10000000,
  parameter int PRESC_W     = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [19:0] load_value,
  input  logic        start_stop,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_units,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_units,
  output logic [3:0]  tenths,
  output logic        running,
  output logic        expired,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t               state, state_n;
  logic [19:0]          cnt, cnt_n;        // {min_tens, min_units, sec_tens, sec_units, tenths}
  logic [19:0]          reload, reload_n;
  logic [PRESC_W-1:0]   presc, presc_n;
  logic                 done_n;
  logic                 tick;
  logic [19:0]          cnt_dec;
  logic [19:0]          load_san;

  // Digit positions 2 and 4 are tens digits (0-5); the rest are 0-9.
  function automatic logic [19:0] bcd_sanitize(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int i = 0; i < 5; i++) begin
      if (i == 2 || i == 4) begin
        if (v[i*4 +: 4] > 4'd5) r[i*4 +: 4] = 4'd5;
      end else begin
        if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
      end
    end
    return r;
  endfunction

  // Mixed-radix decrement: zero digits borrow and wrap to their max,
  // the first non-zero digit absorbs the borrow.
  function automatic logic [19:0] bcd_dec(input logic [19:0] v);
    logic [19:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = (i == 2 || i == 4) ? 4'd5 : 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign load_san = bcd_sanitize(load_value);
  assign cnt_dec  = bcd_dec(cnt);
  assign tick     = (state == RUN) && (presc == PRESC_W'(TICK_CYCLES - 1));

  // State, count and prescaler registers; flags registered from next-state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      reload  <= '0;
      presc   <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      reload  <= reload_n;
      presc   <= presc_n;
      running <= (state_n == RUN);
      expired <= (state_n == DONE);
      done    <= done_n;
    end
  end

  // Next-state: load overrides everything; in RUN the current cycle's
  // prescaler step is always taken, then a start_stop pauses afterwards
  // (so a pause never loses or double-counts a cycle).
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    reload_n = reload;
    presc_n  = presc;
    done_n   = 1'b0;
    if (load) begin
      cnt_n    = load_san;
      reload_n = load_san;
      presc_n  = '0;
      state_n  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_stop && cnt != 20'd0) begin
            state_n = RUN;
            presc_n = '0;
          end
        end
        RUN: begin
          if (tick) begin
            presc_n = '0;
            if (cnt_dec == 20'd0) begin
              done_n = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              if (reload != 20'd0) begin
                cnt_n = reload;
              end else begin
                cnt_n   = 20'd0;
                state_n = DONE;
              end
`else
              cnt_n   = 20'd0;
              state_n = DONE;
`endif
            end else begin
              cnt_n = cnt_dec;
            end
          end else begin
            presc_n = presc + PRESC_W'(1);
          end
          if (start_stop && state_n == RUN) state_n = PAUSE;
        end
        PAUSE: begin
          if (start_stop) state_n = RUN;
        end
        DONE: begin
          state_n = DONE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign min_tens  = cnt[19:16];
  assign min_units = cnt[15:12];
  assign sec_tens  = cnt[11:8];
  assign sec_units = cnt[7:4];
  assign tenths    = cnt[3:0];

endmodule

// File: doc/countdown_timer.md
# countdown_timer

BCD countdown timer, the down-counting counterpart of the stopwatch: loads a preset MM:SS.t value, then decrements one tenth-second per prescaled tick until it reaches 00:00.0. It flags expiry and sits beside the stopwatch, feeding the same five-digit display path.

## Interface
- TICK_CYCLES, 10000000: clock cycles per 0.1 s tick (100 MHz clock); ≥2.
- PRESC_W, 24: prescaler width; must satisfy 2^PRESC_W ≥ TICK_CYCLES.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- load  in  1  single-cycle pulse; latch load_value as new count.
- load_value  in  20  BCD preset {min_tens, min_units, sec_tens, sec_units, tenths}, 4 bits each.
- start_stop  in  1  single-cycle pulse; toggles run/pause.
- min_tens  out  4  BCD 0–5.
- min_units  out  4  BCD 0–9.
- sec_tens  out  4  BCD 0–5.
- sec_units  out  4  BCD 0–9.
- tenths  out  4  BCD 0–9.
- running  out  1  high in RUN.
- expired  out  1  level, high in DONE.
- done  out  1  one-cycle pulse when the count reaches zero.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE, all digits 0, prescaler 0, reload register 0, all flags 0.
- Load: on any state, load → digits = sanitized load_value, reload register = same, prescaler = 0, state → IDLE.
- Sanitize: any units/tenths digit >9 becomes 9; any tens digit >5 becomes 5.
- start_stop behaviour by state:
  - IDLE with count ≠ 0 → RUN, prescaler = 0.
  - IDLE with count = 0 → ignored.
  - RUN → PAUSE.
  - PAUSE → RUN; prescaler resumes from its held value.
  - DONE → ignored.
- load and start_stop in the same cycle: load wins; start_stop is dropped.
- Prescaler runs only in RUN; it holds in PAUSE; it is 0 in IDLE and DONE. tick = (prescaler == TICK_CYCLES-1), and the prescaler wraps to 0 on tick.
- On tick in RUN, BCD decrement with borrow chain tenths → sec_units → sec_tens → min_units → min_tens:
  - a 0 digit borrows and becomes 9 (tens digits become 5);
  - the chain stops at the first non-zero digit, which decrements.
- If the decremented result is 00:00.0: done = 1 for that cycle, state → DONE, expired = 1, running = 0.
- DONE holds the digits at zero until load or reset.
- Reset mid-operation: immediate asynchronous return to the reset values; the reload register is cleared.

## Timing
- All outputs are registered. Digit, running, expired and done outputs change only on clock edges, except on reset assertion.
- start_stop sampled at edge N → running reflects the new state after edge N.
- First decrement occurs TICK_CYCLES cycles after entering RUN from IDLE.
- A preset of P tenths therefore expires P·TICK_CYCLES cycles after start, with no pauses.
- done and the final zero digits appear on the same edge as the terminal tick.
- Load at edge N → digits valid after edge N; running = 0.
- Pause/resume preserves the partial prescaler count, so total run time is exact.

## Configuration
- COUNTDOWN_AUTORELOAD_EN defined: on reaching zero, done pulses and digits reload from the reload register on the same edge.
  - State stays RUN and the prescaler continues from 0; expired stays 0.
  - If the reload register is 0, the block enters DONE as normal.
- COUNTDOWN_AUTORELOAD_EN undefined: DONE/expired behaviour as in Operation. The reload register still exists and is written on load.

## Test plan
(All scenarios use TICK_CYCLES = 4.)
- Reset mid-RUN at arbitrary cycle → all digits 0, running = 0, expired = 0, done = 0 immediately; next start_stop is ignored (count = 0).
- Load 00:00.3, start_stop → decrements to .2, .1, .0 at 4, 8, 12 cycles after start; done is a one-cycle pulse at cycle 12; expired = 1; later start_stop is ignored.
- Load 10:00.0, run one tick → 09:59.9 (full borrow chain).
- Load 59:59.9, run one tick → 59:59.8.
- Load 00:01.0, start, pause after 2 cycles, wait 20, resume → 00:00.9 appears exactly 2 cycles after resume.
- load and start_stop in the same cycle during RUN → state IDLE with the new value, running = 0.
- Load value 0xFFFFF → sanitized to 59:59.9.
- With COUNTDOWN_AUTORELOAD_EN, load 00:00.2, start → done pulses at cycles 8 and 16, digits return to 00:00.2, running stays 1, expired stays 0.
